// File: rtl/ram_pkg.sv
// Shared types, default widths and the byte-lane merge helper for the
// synchronous RAM controller slice.
package ram_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 9;
  localparam int LANE_W     = 8;

  // A disabled lane keeps its stored byte.
  function automatic logic [LANE_W-1:0] merge_lane(
    input logic [LANE_W-1:0] old_byte,
    input logic [LANE_W-1:0] new_byte,
    input logic              en
  );
    return en ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/ram_array.sv
// Reset-free storage: one clocked byte-lane write port and one registered
// read port sharing a single address.
module ram_array
  import ram_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int ADDR_W = DEF_ADDR_W,
  localparam int NB     = DATA_W / LANE_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [NB-1:0]     be,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        mem[addr][LANE_W*i +: LANE_W] <=
          merge_lane(mem[addr][LANE_W*i +: LANE_W], wdata[LANE_W*i +: LANE_W], be[i]);
      end
    end
    if (re) begin
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/sync_ram_ctrl.sv
// Single-port synchronous RAM with registered read, byte-lane writes,
// read/write conflict flagging and an optional zero-fill after reset.
module sync_ram_ctrl
  import ram_pkg::*;
#(
  parameter  int DATA_W         = DEF_DATA_W,
  parameter  int ADDR_W         = DEF_ADDR_W,
  parameter  bit CLEAR_ON_RESET = 1'b1,
  localparam int NB             = DATA_W / LANE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              re,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [NB-1:0]     be,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              err
);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              rd_seen;
  logic              idle;
  logic              clearing;
  logic              rd_acc;
  logic              wr_acc;
  logic              conflict;
  logic              arr_we;
  logic              arr_re;
  logic [NB-1:0]     arr_be;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_q;

  // Arrays carry no reset, so requests are also masked while rst_n is low.
  assign idle     = rst_n && (state == ST_IDLE);
  assign clearing = rst_n && (state == ST_CLEAR);
  assign rd_acc   = idle && re && !we;
  assign wr_acc   = idle && we && !re;
  assign conflict = idle && re && we;

  assign arr_we    = clearing || wr_acc;
  assign arr_re    = rd_acc;
  assign arr_be    = clearing ? '1  : be;
  assign arr_addr  = clearing ? cnt : addr;
  assign arr_wdata = clearing ? '0  : wdata;

  ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .be    (arr_be),
    .re    (arr_re),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .q     (arr_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      busy    <= CLEAR_ON_RESET;
      cnt     <= '0;
      rvalid  <= 1'b0;
      err     <= 1'b0;
      rd_seen <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      case (state)
        ST_CLEAR: begin
          cnt <= cnt + 1'b1;
          // Terminal count is all-ones, so the last word is written before leaving.
          if (cnt == '1) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_IDLE: begin
          rvalid <= rd_acc;
          err    <= conflict;
          if (rd_acc) begin
            rd_seen <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Until the first read after reset the array output is meaningless; show zero.
  assign rdata = rd_seen ? arr_q : '0;

endmodule

// File: tb/tb_sync_ram_ctrl.sv
// Directed self-checking bench: one clearing instance and one instance
// that keeps its contents across reset.
module tb_sync_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, re, we;
  logic [8:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        rvalid, busy, err;

  logic        rst1_n, re1, we1;
  logic [8:0]  addr1;
  logic [31:0] wdata1;
  logic [3:0]  be1;
  logic [31:0] rdata1;
  logic        rvalid1, busy1, err1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sync_ram_ctrl #(.DATA_W(32), .ADDR_W(9), .CLEAR_ON_RESET(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .re(re), .we(we), .addr(addr), .wdata(wdata),
    .be(be), .rdata(rdata), .rvalid(rvalid), .busy(busy), .err(err)
  );

  sync_ram_ctrl #(.DATA_W(32), .ADDR_W(9), .CLEAR_ON_RESET(1'b0)) u_keep (
    .clk(clk), .rst_n(rst1_n), .re(re1), .we(we1), .addr(addr1), .wdata(wdata1),
    .be(be1), .rdata(rdata1), .rvalid(rvalid1), .busy(busy1), .err(err1)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("[TB] %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request on the clearing instance, then sample 1 time unit after the edge.
  task automatic apply_stimulus(input logic r, input logic w, input logic [8:0] a,
                                input logic [31:0] d, input logic [3:0] b);
    re = r; we = w; addr = a; wdata = d; be = b;
    @(posedge clk); #1;
  endtask

  task automatic apply_keep(input logic r, input logic w, input logic [8:0] a,
                            input logic [31:0] d, input logic [3:0] b);
    re1 = r; we1 = w; addr1 = a; wdata1 = d; be1 = b;
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 9'd0, 32'h0, 4'h0);
  endtask

  // Counts busy cycles with re held high; reports whether rvalid ever rose.
  task automatic count_busy(output int cycles, output logic saw_rvalid);
    cycles = 0;
    saw_rvalid = 1'b0;
    while (busy === 1'b1 && cycles < 1000) begin
      apply_stimulus(1'b1, 1'b0, 9'd3, 32'h0, 4'h0);
      if (rvalid !== 1'b0) saw_rvalid = 1'b1;
      cycles++;
    end
    re = 1'b0;
  endtask

  initial begin
    int   ncyc;
    logic saw;
    logic [31:0] exp_pat [5];
    exp_pat[0] = 32'd1; exp_pat[1] = 32'd2; exp_pat[2] = 32'd4;
    exp_pat[3] = 32'd8; exp_pat[4] = 32'd16;

    rst_n = 1'b0; re = 0; we = 0; addr = 0; wdata = 0; be = 0;
    rst1_n = 1'b0; re1 = 0; we1 = 0; addr1 = 0; wdata1 = 0; be1 = 0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_rdata", rdata, 32'h0);
    check_output("reset_rvalid", 32'(rvalid), 32'h0);
    check_output("reset_err", 32'(err), 32'h0);
    check_output("reset_busy", 32'(busy), 32'h1);
    check_output("keep_reset_busy", 32'(busy1), 32'h0);

    // 1: zero-fill duration and cleared contents
    rst_n = 1'b1; rst1_n = 1'b1;
    count_busy(ncyc, saw);
    check_output("clear_cycles", 32'(ncyc), 32'd512);
    check_output("clear_no_rvalid", 32'(saw), 32'h0);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, 1'b0, 9'(i), 32'h0, 4'h0);
      check_output("clr_rvalid", 32'(rvalid), 32'h1);
      check_output("clr_rdata", rdata, 32'h0);
    end
    idle_cycles(1);
    check_output("idle_rvalid", 32'(rvalid), 32'h0);

    // 2: full-word writes then back-to-back reads
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b1, 9'(i), exp_pat[i], 4'hF);
    check_output("write_no_rvalid", 32'(rvalid), 32'h0);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, 1'b0, 9'(i), 32'h0, 4'h0);
      check_output("b2b_rvalid", 32'(rvalid), 32'h1);
      check_output("b2b_rdata", rdata, exp_pat[i]);
    end

    // 3: partial byte-lane write
    apply_stimulus(1'b0, 1'b1, 9'd7, 32'hFFFFFFFF, 4'hF);
    apply_stimulus(1'b0, 1'b1, 9'd7, 32'h0, 4'b0010);
    apply_stimulus(1'b1, 1'b0, 9'd7, 32'h0, 4'h0);
    check_output("lane_rdata", rdata, 32'hFFFF00FF);

    // 4: conflict, then be=0 no-op and read-after-write
    apply_stimulus(1'b1, 1'b1, 9'd3, 32'h0, 4'hF);
    check_output("conf_err", 32'(err), 32'h1);
    check_output("conf_rvalid", 32'(rvalid), 32'h0);
    check_output("conf_rdata", rdata, 32'hFFFF00FF);
    idle_cycles(1);
    check_output("conf_err_pulse", 32'(err), 32'h0);
    check_output("conf_rdata_hold", rdata, 32'hFFFF00FF);
    apply_stimulus(1'b0, 1'b1, 9'd3, 32'h0, 4'h0);
    apply_stimulus(1'b1, 1'b0, 9'd3, 32'h0, 4'h0);
    check_output("conf_readback", rdata, 32'd8);
    apply_stimulus(1'b0, 1'b1, 9'd5, 32'hA5A5_0F0F, 4'hF);
    apply_stimulus(1'b1, 1'b0, 9'd5, 32'h0, 4'h0);
    check_output("raw_rdata", rdata, 32'hA5A5_0F0F);

    // 6a: extreme addresses do not alias
    apply_stimulus(1'b0, 1'b1, 9'd511, 32'hDEADBEEF, 4'hF);
    apply_stimulus(1'b0, 1'b1, 9'd0, 32'h12345678, 4'hF);
    apply_stimulus(1'b1, 1'b0, 9'd511, 32'h0, 4'h0);
    check_output("top_addr", rdata, 32'hDEADBEEF);
    apply_stimulus(1'b1, 1'b0, 9'd0, 32'h0, 4'h0);
    check_output("bot_addr", rdata, 32'h12345678);
    check_output("bot_rvalid", 32'(rvalid), 32'h1);

    // 5: asynchronous reset, then reset again in the middle of the clear
    re = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_output("async_rdata", rdata, 32'h0);
    check_output("async_rvalid", 32'(rvalid), 32'h0);
    check_output("async_err", 32'(err), 32'h0);
    check_output("async_busy", 32'(busy), 32'h1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 100; i++) begin
      apply_stimulus(1'b1, 1'b0, 9'd0, 32'h0, 4'h0);
      if (rvalid !== 1'b0) saw = 1'b1;
    end
    check_output("midclear_no_rvalid", 32'(saw), 32'h0);
    check_output("midclear_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    re = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    count_busy(ncyc, saw);
    check_output("restart_cycles", 32'(ncyc), 32'd512);
    check_output("restart_no_rvalid", 32'(saw), 32'h0);
    apply_stimulus(1'b1, 1'b0, 9'd511, 32'h0, 4'h0);
    check_output("recleared_top", rdata, 32'h0);
    apply_stimulus(1'b1, 1'b0, 9'd3, 32'h0, 4'h0);
    check_output("recleared_3", rdata, 32'h0);

    // 6b: contents survive reset when zero-fill is disabled
    apply_keep(1'b0, 1'b1, 9'd511, 32'hDEADBEEF, 4'hF);
    apply_keep(1'b0, 1'b1, 9'd0, 32'h12345678, 4'hF);
    apply_keep(1'b1, 1'b0, 9'd511, 32'h0, 4'h0);
    check_output("keep_pre_top", rdata1, 32'hDEADBEEF);
    re1 = 1'b0;
    rst1_n = 1'b0;
    saw = 1'b0;
    #1;
    check_output("keep_async_rdata", rdata1, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (busy1 !== 1'b0) saw = 1'b1;
    end
    rst1_n = 1'b1;
    #1;
    if (busy1 !== 1'b0) saw = 1'b1;
    check_output("keep_busy_low", 32'(saw), 32'h0);
    apply_keep(1'b1, 1'b0, 9'd511, 32'h0, 4'h0);
    check_output("keep_top", rdata1, 32'hDEADBEEF);
    check_output("keep_rvalid", 32'(rvalid1), 32'h1);
    apply_keep(1'b1, 1'b0, 9'd0, 32'h0, 4'h0);
    check_output("keep_bot", rdata1, 32'h12345678);
    check_output("keep_err", 32'(err1), 32'h0);
    re1 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sync_ram_ctrl.md
Name: sync_ram_ctrl

Overview:
Parametrised single-port synchronous RAM with registered read, byte-lane write enables, explicit read/write conflict detection and an optional zero-fill sequencer after reset. It is the clocked successor to the team's unclocked 512x32 tri-state-bus RAM. It replaces the bidirectional data bus with separate write and read buses plus a read-valid strobe, and sits behind the datapath's load/store unit.

Parameters:
DATA_W, 32, data word width in bits; must be a multiple of 8
ADDR_W, 9, address width; depth = 2**ADDR_W words
CLEAR_ON_RESET, 1, 1 = zero-fill every word after reset; 0 = contents untouched by reset
NB (localparam), DATA_W/8, number of byte lanes

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
re  in  1  read request, sampled at posedge
we  in  1  write request, sampled at posedge
addr  in  ADDR_W  word address
wdata  in  DATA_W  write data
be  in  NB  byte enables; bit i gates wdata[8i+7:8i]
rdata  out  DATA_W  registered read data
rvalid  out  1  one-cycle pulse: rdata holds the result of the read accepted on the previous edge
busy  out  1  high while the clear sequence runs; requests are ignored
err  out  1  one-cycle pulse: re and we were both high on an accepted edge

Behaviour:
- Reset (rst_n=0, asynchronous): rdata=0, rvalid=0, err=0, clear counter=0.
- Reset state: CLEAR if CLEAR_ON_RESET=1, otherwise IDLE. busy=1 during reset iff CLEAR_ON_RESET=1.
- FSM states: CLEAR and IDLE.
- CLEAR: each cycle writes 0 to all lanes of mem[cnt], then cnt++. The state moves to IDLE on the edge that writes address 2**ADDR_W-1. CLEAR lasts exactly 2**ADDR_W cycles after rst_n deasserts. busy = (state==CLEAR).
- Requests during CLEAR are dropped: no memory change, no rvalid, no err.
- Reset asserted mid-CLEAR restarts the sequence at address 0. There is no partial resume.
- IDLE write (we=1, re=0): on the edge, mem[addr] lane i is updated where be[i]=1; lanes with be[i]=0 are preserved. be=0 is a legal no-op. No response strobe.
- IDLE read (re=1, we=0): on edge N, rdata<=mem[addr]. rvalid=1 for the cycle after edge N. Latency is 1 cycle.
- Back-to-back reads: one per cycle, rvalid stays high continuously.
- rdata holds its last value when rvalid=0. It is never driven to Z or X after reset.
- Read-after-write: a read of an address issued the cycle after a write returns the new data. There is no forwarding requirement, because only one access per cycle is possible.
- Conflict (re=1 and we=1 in IDLE): no memory access, rdata unchanged, rvalid=0 next cycle, err=1 for exactly one cycle after the edge.
- Idle cycle (re=0, we=0): rvalid=0, err=0.
- Address range: addr spans exactly 2**ADDR_W words with no aliasing.
- Clear counter: ADDR_W bits wide. Terminal count is detected on all-ones, never on wrap to 0.
- CLEAR_ON_RESET=0: after power-up, memory is X in simulation. Contents are preserved across rst_n pulses, and busy is constantly 0.
- Widths: no arithmetic on data. Only the clear counter increments, modulo 2**ADDR_W.

Decomposition:
- Package ram_pkg:
  - FSM state typedef (ST_CLEAR, ST_IDLE)
  - default width constants
  - function for the byte-lane merge
- Sub-module ram_array: pure storage with one clocked write port (per-lane enables) and one registered read port, no reset.
- sync_ram_ctrl: owns the FSM, clear counter, conflict detection, and the rvalid/err registers. It muxes the clear writes onto the array port.

Test Plan:
1. Defaults; release rst_n; count busy cycles, then read addr 0..4 -> busy high exactly 512 cycles; each read returns 0 with rvalid one cycle after re.
2. Write be=4'hF with data 1,2,4,8,16 to addr 0..4; read addr 0..4 back-to-back -> rdata 1,2,4,8,16 on consecutive cycles, rvalid high for 5 cycles.
3. Write 32'hFFFFFFFF to addr 7; then write be=4'b0010, wdata=0 to addr 7; read addr 7 -> rdata 32'hFFFF00FF.
4. After scenario 2, drive re=1 and we=1 with addr=3, wdata=0 -> err pulses 1 cycle; rvalid stays 0 and rdata stays unchanged; a subsequent read of addr 3 returns 8.
5. Pull rst_n low at CLEAR cycle 100 for 3 cycles, then release -> rdata, rvalid and err go to 0 immediately, without waiting for a clock edge; busy is high for a full 512 cycles after release; re pulses during busy produce no rvalid.
6. Write 32'hDEADBEEF to addr 511 and 32'h12345678 to addr 0; read 511 then 0 -> 32'hDEADBEEF then 32'h12345678, confirming no aliasing. With CLEAR_ON_RESET=0, reset and re-read -> both values are preserved and busy never rises.
